// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// reset_sequencer_pkg : shared state encodings and helpers for reset_sequencer
// Revision 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_e;

  localparam int unsigned DROP_CNT_W = 8;

  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_sync_debounce.sv
// ============================================================================
// sync_debounce : SYNC_STAGES-deep synchroniser with optional stability filter
// (filter built only when RESET_SEQUENCER_DEBOUNCE_EN is defined). Revision 1.0
// ============================================================================
`default_nettype none

module sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic deb_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("sync_debounce: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("sync_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef RESET_SEQUENCER_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             deb_q;

  // Output flips only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      deb_q <= 1'b0;
    end else if (sync_s != deb_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_q <= sync_s;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

  assign deb_o = deb_q;
`else
  assign deb_o = sync_s;
`endif

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : PLL-lock / button driven SoC reset FSM (ASSERT..RUN).
// Button debounce enabled by RESET_SEQUENCER_DEBOUNCE_EN. Revision 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int HOLD_CYCLES     = 1024,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pll_locked,
  input  logic                  btn,
  output logic                  soc_reset,
  output logic                  ready,
  output logic [1:0]            state,
  output logic [DROP_CNT_W-1:0] lock_drop_count
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("reset_sequencer: HOLD_CYCLES must be at least 1");
  end

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   locked_s;
  logic                   btn_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lock_sync_q <= '0;
    else       lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = lock_sync_q[SYNC_STAGES-1];

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (btn),
    .deb_o   (btn_d)
  );

  state_e                  state_q;
  logic [HOLD_W-1:0]       hold_cnt_q;
  logic                    soc_reset_q;
  logic                    ready_q;
  logic [DROP_CNT_W-1:0]   drop_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= '0;
      soc_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (!btn_d) state_q <= ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= '0;
          end
        end
        ST_HOLD: begin
          // Losing lock wins over completing the hold period.
          if (!locked_s) begin
            state_q    <= ST_WAIT_LOCK;
            drop_cnt_q <= sat_inc(drop_cnt_q);
          end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
            state_q     <= ST_RUN;
            soc_reset_q <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s || btn_d) begin
            state_q     <= ST_ASSERT;
            soc_reset_q <= 1'b1;
            ready_q     <= 1'b0;
            if (!locked_s) drop_cnt_q <= sat_inc(drop_cnt_q);
          end
        end
        default: begin
          state_q     <= ST_ASSERT;
          soc_reset_q <= 1'b1;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign state           = state_q;
  assign soc_reset       = soc_reset_q;
  assign ready           = ready_q;
  assign lock_drop_count = drop_cnt_q;

endmodule

`default_nettype wire
